// File: rtl/ppi_mode_controller.sv
// PPI mode/handshake sequencer: commits control-word writes, drives port direction
// and strobe controls, and runs the port A mode-1 strobed handshake.
module ppi_mode_controller #(
    parameter logic [7:0] CTRL_RESET = 8'h9B,
    parameter logic [7:0] PC_RESET   = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       CS_n,
    input  logic       RD_n,
    input  logic       WR_n,
    input  logic [1:0] A,
    input  logic [7:0] D_in,
    input  logic       STB_A_n,
    input  logic       ACK_A_n,
    output logic [7:0] ctrl_word,
    output logic       mode_A,
    output logic       dir_A,
    output logic       dir_B,
    output logic       dir_C_up,
    output logic       dir_C_lo,
    output logic [7:0] pc_oe,
    output logic [7:0] pc_out,
    output logic       wr_A,
    output logic       wr_B,
    output logic       wr_C,
    output logic       latch_A,
    output logic       data_bus_drive,
    output logic       IBF_A,
    output logic       INTR_A,
    output logic       OBF_A_n
);

    typedef enum logic [1:0] {IN_EMPTY, IN_FULL, OUT_EMPTY, OUT_FULL} pa_state_t;

    pa_state_t  state_q, state_d;
    logic [7:0] ctrl_q, ctrl_d, pc_q, pc_d;
    logic       inte_q, inte_d, ibf_q, ibf_d, intr_q, intr_d, obf_n_q, obf_n_d;
    logic       wr_a_q, wr_a_d, wr_b_q, wr_b_d, wr_c_q, wr_c_d, latch_q, latch_d;
    logic       rd_q, wr_q, stb_q, ack_q;

    logic       sel, wr_commit, rd_start_a, rd_end_a;
    logic       stb_fall, stb_rise, ack_fall, ack_rise;
    logic       m1_in, m1_out;

    // RD_n and WR_n low together never qualify an access
    assign sel        = !CS_n;
    assign wr_commit  = sel && !wr_q && WR_n && RD_n;
    assign rd_start_a = sel && rd_q && !RD_n && WR_n && (A == 2'b00);
    assign rd_end_a   = sel && !rd_q && RD_n && WR_n && (A == 2'b00);
    assign stb_fall   = stb_q && !STB_A_n;
    assign stb_rise   = !stb_q && STB_A_n;
    assign ack_fall   = ack_q && !ACK_A_n;
    assign ack_rise   = !ack_q && ACK_A_n;

    assign m1_in  = ctrl_q[5] && ctrl_q[4];
    assign m1_out = ctrl_q[5] && !ctrl_q[4];

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        inte_d  = inte_q;
        ibf_d   = ibf_q;
        intr_d  = intr_q;
        obf_n_d = obf_n_q;
        wr_a_d  = 1'b0;
        wr_b_d  = 1'b0;
        wr_c_d  = 1'b0;
        latch_d = 1'b0;

        if (wr_commit && A == 2'b11 && D_in[7]) begin
            ctrl_d  = D_in;
            pc_d    = PC_RESET;
            inte_d  = 1'b0;
            ibf_d   = 1'b0;
            intr_d  = 1'b0;
            obf_n_d = 1'b1;
            state_d = D_in[4] ? IN_EMPTY : OUT_EMPTY;
        end else begin
            if (wr_commit) begin
                case (A)
                    2'b00: wr_a_d = 1'b1;
                    2'b01: wr_b_d = 1'b1;
                    2'b10: begin
                        wr_c_d = 1'b1;
                        pc_d   = D_in;
                    end
                    default: begin
                        // Handshake-driven bits keep their latch value; INTE bit also updates the latch
                        if (!((m1_in  && (D_in[3:1] == 3'd3 || D_in[3:1] == 3'd5)) ||
                              (m1_out && (D_in[3:1] == 3'd3 || D_in[3:1] == 3'd7))))
                            pc_d[D_in[3:1]] = D_in[0];
                        if ((m1_in && D_in[3:1] == 3'd4) || (m1_out && D_in[3:1] == 3'd6))
                            inte_d = D_in[0];
                    end
                endcase
            end

            if (m1_in) begin
                if (rd_start_a) intr_d = 1'b0;
                if (stb_rise && state_q == IN_FULL && inte_q) intr_d = 1'b1;
                if (rd_end_a) begin
                    ibf_d   = 1'b0;
                    state_d = IN_EMPTY;
                end
                if (stb_fall) begin
                    latch_d = 1'b1;
                    ibf_d   = 1'b1;
                    state_d = IN_FULL;
                end
            end else if (m1_out) begin
                if (ack_fall) obf_n_d = 1'b1;
                if (ack_rise && obf_n_q && inte_q) begin
                    intr_d  = 1'b1;
                    state_d = OUT_EMPTY;
                end
                if (wr_commit && A == 2'b00) begin
                    obf_n_d = 1'b0;
                    intr_d  = 1'b0;
                    state_d = OUT_FULL;
                end
            end else begin
                ibf_d   = 1'b0;
                intr_d  = 1'b0;
                obf_n_d = 1'b1;
                state_d = ctrl_q[4] ? IN_EMPTY : OUT_EMPTY;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IN_EMPTY;
            ctrl_q  <= CTRL_RESET;
            pc_q    <= PC_RESET;
            inte_q  <= 1'b0;
            ibf_q   <= 1'b0;
            intr_q  <= 1'b0;
            obf_n_q <= 1'b1;
            wr_a_q  <= 1'b0;
            wr_b_q  <= 1'b0;
            wr_c_q  <= 1'b0;
            latch_q <= 1'b0;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            stb_q   <= 1'b1;
            ack_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            inte_q  <= inte_d;
            ibf_q   <= ibf_d;
            intr_q  <= intr_d;
            obf_n_q <= obf_n_d;
            wr_a_q  <= wr_a_d;
            wr_b_q  <= wr_b_d;
            wr_c_q  <= wr_c_d;
            latch_q <= latch_d;
            rd_q    <= RD_n;
            wr_q    <= WR_n;
            stb_q   <= STB_A_n;
            ack_q   <= ACK_A_n;
        end
    end

    always_comb begin
        pc_out = pc_q;
        pc_oe  = {{4{!ctrl_q[3]}}, {4{!ctrl_q[0]}}};
        if (m1_in) begin
            pc_out[3] = intr_q;
            pc_out[5] = ibf_q;
            pc_oe[3]  = 1'b1;
            pc_oe[5]  = 1'b1;
            pc_oe[4]  = 1'b0;
        end else if (m1_out) begin
            pc_out[3] = intr_q;
            pc_out[7] = obf_n_q;
            pc_oe[3]  = 1'b1;
            pc_oe[7]  = 1'b1;
            pc_oe[6]  = 1'b0;
        end
    end

    assign ctrl_word      = ctrl_q;
    assign mode_A         = ctrl_q[5];
    assign dir_A          = ctrl_q[4];
    assign dir_C_up       = ctrl_q[3];
    assign dir_B          = ctrl_q[1];
    assign dir_C_lo       = ctrl_q[0];
    assign wr_A           = wr_a_q;
    assign wr_B           = wr_b_q;
    assign wr_C           = wr_c_q;
    assign latch_A        = latch_q;
    assign IBF_A          = ibf_q;
    assign INTR_A         = intr_q;
    assign OBF_A_n        = obf_n_q;
    assign data_bus_drive = !CS_n && !RD_n && WR_n && (A != 2'b11);

endmodule
